stream_to_axi_w: RTL and testbench

- Receive-side decoder for the write-data capture stream.
- Consumes a packet of one metadata beat, 1..BURST_SIZE data beats, then one packed-strobe beat flagged last.
- Rebuilds the original AXI write-data burst (id, data, per-beat strobes, wlast) and replays it on an AXI master W channel.
- Sits at the far end of the Ethernet link, in front of the replay memory port.

---
 rtl/stream_to_axi_w.sv | 152 +++++++++++++++
 tb/tb_stream_to_axi_w.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/stream_to_axi_w.sv
// Stream-to-AXI W decoder: collects one metadata beat, up to BURST_SIZE data beats and a
// packed-strobe beat, then replays the burst on an AXI master W channel.
//
// state   | meaning
// --------+---------------------------------------------------------------
// META    | waiting for a metadata beat (type tag + id)
// COLLECT | buffering data beats until the strobe beat flagged last
// DROP    | discarding a bad packet up to and including its last beat
// REPLAY  | driving buffered beats on W; stream input is back-pressured
module stream_to_axi_w #(
  parameter int                           DATA_WIDTH        = 128,
  parameter int                           ID_WIDTH          = 32,
  parameter int                           USER_WIDTH        = 64,
  parameter int                           STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = 3'b011,
  parameter int                           BURST_SIZE        = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic [ID_WIDTH-1:0]     AXIM_wid,
  output logic [DATA_WIDTH-1:0]   AXIM_wdata,
  output logic [DATA_WIDTH/8-1:0] AXIM_wstrb,
  output logic                    AXIM_wlast,
  output logic [USER_WIDTH-1:0]   AXIM_wuser,
  output logic                    AXIM_wvalid,
  input  logic                    AXIM_wready,
  output logic                    pkt_done,
  output logic                    err,
  output logic [15:0]             err_count
);

  localparam int S  = DATA_WIDTH / 8;
  localparam int SW = BURST_SIZE * S;
  localparam int CW = $clog2(BURST_SIZE + 1);
  localparam int IW = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  if ((SW + STREAM_TYPE_WIDTH > DATA_WIDTH) || (ID_WIDTH + STREAM_TYPE_WIDTH > DATA_WIDTH)) begin : g_bad_cfg
    $error("stream_to_axi_w: BURST_SIZE/ID_WIDTH do not fit in one stream beat");
  end

  typedef enum logic [1:0] {META, COLLECT, DROP, REPLAY} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt, idx, idx_nxt, sel;
  logic [ID_WIDTH-1:0]   id_q, id_nxt;
  logic [SW-1:0]         strb_q, strb_nxt;
  logic                  s_ready_q, buf_we, err_c;
  logic [15:0]           err_count_q;
  logic [DATA_WIDTH-1:0] data_buf [BURST_SIZE];
  logic [S-1:0]          wstrb_c;

  logic accept, type_ok, w_hs, last_beat;
  assign accept    = s_valid & s_ready_q;
  assign type_ok   = (s_data[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH] == STREAM_TYPE);
  assign last_beat = (idx == cnt - ONE);
  assign w_hs      = AXIM_wvalid & AXIM_wready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    id_nxt    = id_q;
    strb_nxt  = strb_q;
    buf_we    = 1'b0;
    err_c     = 1'b0;
    case (state)
      META: if (accept) begin
        if (type_ok && !s_last) begin
          id_nxt    = s_data[ID_WIDTH-1:0];
          cnt_nxt   = '0;
          state_nxt = COLLECT;
        end else begin
          err_c = 1'b1;
          if (!s_last) state_nxt = DROP;
        end
      end
      COLLECT: if (accept) begin
        if (!s_last) begin
          if (cnt == CW'(BURST_SIZE)) begin
            err_c     = 1'b1;
            state_nxt = DROP;
          end else begin
            buf_we  = 1'b1;
            cnt_nxt = cnt + ONE;
          end
        end else if (!type_ok || cnt == '0) begin
          err_c     = 1'b1;
          state_nxt = META;
        end else begin
          strb_nxt  = s_data[SW-1:0];
          idx_nxt   = '0;
          state_nxt = REPLAY;
        end
      end
      DROP: if (accept && s_last) state_nxt = META;
      REPLAY: if (w_hs) begin
        if (last_beat) state_nxt = META;
        else           idx_nxt   = idx + ONE;
      end
      default: state_nxt = META;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= META;
      cnt         <= '0;
      idx         <= '0;
      id_q        <= '0;
      strb_q      <= '0;
      s_ready_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      id_q      <= id_nxt;
      strb_q    <= strb_nxt;
      s_ready_q <= (state_nxt != REPLAY);
      if (err_c && err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) data_buf[cnt[IW-1:0]] <= s_data;
  end

  // Sender shifts each beat's strobe in at the bottom, so beat 0 is the highest slice.
  assign sel = cnt - ONE - idx;
  always_comb begin
    wstrb_c = '0;
    for (int k = 0; k < BURST_SIZE; k++)
      if (sel == CW'(k)) wstrb_c = strb_q[k*S +: S];
  end

  assign s_ready     = s_ready_q;
  assign AXIM_wvalid = (state == REPLAY);
  assign AXIM_wlast  = AXIM_wvalid & last_beat;
  assign AXIM_wid    = id_q;
  assign AXIM_wdata  = data_buf[idx[IW-1:0]];
  assign AXIM_wstrb  = wstrb_c;
  assign AXIM_wuser  = '0;
  assign pkt_done    = w_hs & last_beat;
  assign err         = err_c;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_stream_to_axi_w.sv
// Directed per-cycle vector bench for stream_to_axi_w, plus an asynchronous reset during replay.
module tb_stream_to_axi_w;

  logic         clk = 1'b0;
  logic         resetn;
  logic         s_valid, s_ready, s_last;
  logic [127:0] s_data;
  logic [31:0]  AXIM_wid;
  logic [127:0] AXIM_wdata;
  logic [15:0]  AXIM_wstrb;
  logic         AXIM_wlast, AXIM_wvalid, AXIM_wready;
  logic [63:0]  AXIM_wuser;
  logic         pkt_done, err;
  logic [15:0]  err_count;

  stream_to_axi_w dut (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_data(s_data),
    .AXIM_wid(AXIM_wid), .AXIM_wdata(AXIM_wdata), .AXIM_wstrb(AXIM_wstrb),
    .AXIM_wlast(AXIM_wlast), .AXIM_wuser(AXIM_wuser), .AXIM_wvalid(AXIM_wvalid),
    .AXIM_wready(AXIM_wready), .pkt_done(pkt_done), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v, l, wr;
    logic [127:0] d;
    logic         rdy, wv, wl, er, dn;
    logic [127:0] wd;
    logic [15:0]  ws;
    logic [31:0]  wid;
  } vec_t;

  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  int          model_cnt = 0;

  function automatic logic [127:0] meta(logic [2:0] t, logic [31:0] id);
    return {t, 93'd0, id};
  endfunction
  function automatic logic [127:0] sb(logic [2:0] t, logic [63:0] f);
    return {t, 61'd0, f};
  endfunction
  function automatic logic [127:0] dat(int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic s_row(logic v, logic l, logic [127:0] d, logic er = 1'b0);
    vec_t r;
    r.v = v; r.l = l; r.d = d; r.wr = 1'b1;
    r.rdy = 1'b1; r.wv = 1'b0; r.wl = 1'b0; r.er = er; r.dn = 1'b0;
    r.wd = '0; r.ws = '0; r.wid = '0;
    tbl.push_back(r);
  endtask
  task automatic w_row(logic wr, logic [127:0] wd, logic [15:0] ws, logic wl, logic [31:0] wid);
    vec_t r;
    r.v = 1'b0; r.l = 1'b0; r.d = '0; r.wr = wr;
    r.rdy = 1'b0; r.wv = 1'b1; r.wl = wl; r.er = 1'b0; r.dn = wl & wr;
    r.wd = wd; r.ws = ws; r.wid = wid;
    tbl.push_back(r);
  endtask

  task automatic chk(string name, int row, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
    end
  endtask

  task automatic run_row(vec_t r, int n);
    @(posedge clk);
    #1;
    s_valid = r.v; s_last = r.l; s_data = r.d; AXIM_wready = r.wr;
    @(negedge clk);
    chk("s_ready", n, 128'(s_ready), 128'(r.rdy));
    chk("wvalid", n, 128'(AXIM_wvalid), 128'(r.wv));
    chk("err", n, 128'(err), 128'(r.er));
    chk("pkt_done", n, 128'(pkt_done), 128'(r.dn));
    chk("err_count", n, 128'(err_count), 128'(model_cnt));
    chk("wuser", n, 128'(AXIM_wuser), 128'd0);
    chk("wlast", n, 128'(AXIM_wlast), 128'(r.wl));
    if (r.wv) begin
      chk("wdata", n, AXIM_wdata, r.wd);
      chk("wstrb", n, 128'(AXIM_wstrb), 128'(r.ws));
      chk("wid", n, 128'(AXIM_wid), 128'(r.wid));
    end
    if (r.er && model_cnt < 16'hFFFF) model_cnt++;
  endtask

  task automatic run_table(int base);
    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], base + i);
    tbl.delete();
  endtask

  initial begin
    resetn = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; AXIM_wready = 1'b0;
    #12;
    chk("rst_s_ready", -1, 128'(s_ready), 128'd0);
    chk("rst_wvalid", -1, 128'(AXIM_wvalid), 128'd0);
    chk("rst_wlast", -1, 128'(AXIM_wlast), 128'd0);
    chk("rst_err", -1, 128'(err), 128'd0);
    chk("rst_pkt_done", -1, 128'(pkt_done), 128'd0);
    chk("rst_err_count", -1, 128'(err_count), 128'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // nominal 4-beat packet
    s_row(1, 0, meta(3'b011, 32'hA5));
    for (int i = 0; i < 4; i++) s_row(1, 0, dat(i));
    s_row(1, 1, sb(3'b011, 64'h000F_00FF_0FFF_FFFF));
    w_row(1, dat(0), 16'h000F, 0, 32'hA5);
    w_row(1, dat(1), 16'h00FF, 0, 32'hA5);
    w_row(1, dat(2), 16'h0FFF, 0, 32'hA5);
    w_row(1, dat(3), 16'hFFFF, 1, 32'hA5);
    s_row(0, 0, '0);
    // single beat with wready stalled
    s_row(1, 0, meta(3'b011, 32'h1234));
    s_row(1, 0, dat(10));
    s_row(1, 1, sb(3'b011, 64'h8001));
    for (int i = 0; i < 5; i++) w_row(0, dat(10), 16'h8001, 1, 32'h1234);
    w_row(1, dat(10), 16'h8001, 1, 32'h1234);
    s_row(0, 0, '0);
    // wrong-type metadata, packet dropped, next packet fine
    s_row(1, 0, meta(3'b010, 32'h77), 1);
    s_row(1, 0, dat(30));
    s_row(1, 0, dat(31));
    s_row(1, 1, sb(3'b011, 64'h0));
    s_row(1, 0, meta(3'b011, 32'h55));
    s_row(1, 0, dat(20));
    s_row(1, 0, dat(21));
    s_row(1, 1, sb(3'b011, 64'h00F0_0F00));
    w_row(1, dat(20), 16'h00F0, 0, 32'h55);
    w_row(1, dat(21), 16'h0F00, 1, 32'h55);
    s_row(0, 0, '0);
    // overflow: fifth data beat
    s_row(1, 0, meta(3'b011, 32'h9));
    for (int i = 0; i < 4; i++) s_row(1, 0, dat(40 + i));
    s_row(1, 0, dat(44), 1);
    s_row(1, 0, dat(45));
    s_row(1, 1, sb(3'b011, 64'hFFFF));
    s_row(0, 0, '0);
    // empty packet
    s_row(1, 0, meta(3'b011, 32'h3));
    s_row(1, 1, sb(3'b011, 64'hFFFF), 1);
    s_row(0, 0, '0);
    // bad single-beat packet stays in META; bad multi-beat one goes to DROP
    s_row(1, 1, meta(3'b010, 32'h0), 1);
    s_row(1, 0, meta(3'b111, 32'h0), 1);
    s_row(1, 1, dat(0));
    // strobe beat with wrong type
    s_row(1, 0, meta(3'b011, 32'h4));
    s_row(1, 0, dat(50));
    s_row(1, 1, sb(3'b001, 64'h1), 1);
    s_row(0, 0, '0);
    run_table(0);

    // asynchronous reset during the second replay beat
    s_row(1, 0, meta(3'b011, 32'hA5));
    for (int i = 0; i < 3; i++) s_row(1, 0, dat(60 + i));
    s_row(1, 1, sb(3'b011, 64'h0000_0003_0030_0300));
    w_row(1, dat(60), 16'h0003, 0, 32'hA5);
    run_table(100);
    @(posedge clk);
    #1 AXIM_wready = 1'b0;
    chk("beat2_wvalid", 200, 128'(AXIM_wvalid), 128'd1);
    chk("beat2_wdata", 200, AXIM_wdata, dat(61));
    chk("beat2_wstrb", 200, 128'(AXIM_wstrb), 128'h0030);
    #2 resetn = 1'b0;
    #1;
    chk("async_wvalid", 201, 128'(AXIM_wvalid), 128'd0);
    chk("async_wlast", 201, 128'(AXIM_wlast), 128'd0);
    chk("async_s_ready", 201, 128'(s_ready), 128'd0);
    chk("async_err_count", 201, 128'(err_count), 128'd0);
    model_cnt = 0;
    @(posedge clk); #1 resetn = 1'b1;

    s_row(1, 0, meta(3'b011, 32'hBEEF));
    s_row(1, 0, dat(70));
    s_row(1, 0, dat(71));
    s_row(1, 1, sb(3'b011, 64'hFFFF_0001));
    w_row(1, dat(70), 16'hFFFF, 0, 32'hBEEF);
    w_row(1, dat(71), 16'h0001, 1, 32'hBEEF);
    s_row(0, 0, '0);
    run_table(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
